// File: rtl/tdsp_port_pkg.sv
// rtl/tdsp_port_pkg.sv - shared types and defaults for the tdsp pad-port arbiter
package tdsp_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Requester slots on the shared pad bus
  localparam int REQ_DSP  = 0;
  localparam int REQ_TDIG = 1;
  localparam int REQ_SPI  = 2;

  localparam int          DW_DEF       = 16;
  localparam logic [15:0] IDLE_VAL_DEF = 16'h0000;

endpackage

// File: rtl/tdsp_rr_pick.sv
// rtl/tdsp_rr_pick.sv - combinational round-robin first-one finder
module tdsp_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      rr_ptr,
  output logic [1:0]      gnt_idx,
  output logic            any
);

  // Scan upward from rr_ptr, wrapping, and keep the first asserted request
  always_comb begin
    int idx;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!any && (|(req & (NREQ'(1) << idx)))) begin
        any     = 1'b1;
        gnt_idx = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/tdsp_port_arb.sv
// rtl/tdsp_port_arb.sv - round-robin sequencer for the shared tdsp pad output bus
module tdsp_port_arb
  import tdsp_port_pkg::*;
#(
  parameter int             NREQ      = 3,
  parameter int             DW        = DW_DEF,
  parameter int             MAX_BURST = 4,
  parameter logic [DW-1:0]  IDLE_VAL  = DW'(IDLE_VAL_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               test_mode,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    ready,
  output logic [DW-1:0]      port_o,
  output logic               port_valid_o,
  output logic [1:0]         port_src_o,
  output logic               busy_o
);

  // burst_cnt stops here; reaching it with a transfer closes the grant
  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [1:0]      gnt_idx;
  logic [3:0]      burst_cnt;
  logic [1:0]      pick_idx;
  logic            pick_any;
  logic [1:0]      ptr_nxt;
  logic [NREQ-1:0] sel;
  logic [DW-1:0]   data_gnt;
  logic            req_gnt;
  logic            xfer;

  tdsp_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // One-hot decode of the current owner and its data word
  always_comb begin
    sel      = '0;
    data_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel[i] = (gnt_idx == 2'(i));
      if (sel[i]) data_gnt = data[i*DW +: DW];
    end
  end

  assign req_gnt = |(req & sel);
  assign ready   = (state == GRANT && !test_mode) ? sel : '0;
  assign xfer    = (state == GRANT) && !test_mode && req_gnt;
  assign ptr_nxt = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
  assign busy_o  = (state != IDLE);

  // Arbitration FSM plus the pad-facing output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      gnt_idx      <= '0;
      port_o       <= IDLE_VAL;
      port_valid_o <= 1'b0;
      port_src_o   <= '0;
    end else begin
      // Bus idles unless a word is accepted below; port_src_o keeps the last owner
      port_o       <= IDLE_VAL;
      port_valid_o <= 1'b0;
      if (test_mode) begin
        // Scan park: drop any burst without advancing the round-robin pointer
        state     <= IDLE;
        burst_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pick_any) begin
              gnt_idx   <= pick_idx;
              burst_cnt <= '0;
              state     <= GRANT;
            end
          end
          GRANT: begin
            if (xfer) begin
              port_o       <= data_gnt;
              port_valid_o <= 1'b1;
              port_src_o   <= gnt_idx;
              if (burst_cnt != LAST) burst_cnt <= burst_cnt + 4'd1;
            end
            if (!req_gnt || burst_cnt == LAST) begin
              state  <= TURN;
              rr_ptr <= ptr_nxt;
            end
          end
          TURN:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdsp_port_arb.sv
// tb/tb_tdsp_port_arb.sv - self-checking bench for tdsp_port_arb
module tb_tdsp_port_arb;

  localparam int NREQ      = 3;
  localparam int DW        = 16;
  localparam int MAX_BURST = 4;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              test_mode = 1'b0;
  logic [NREQ-1:0]   req       = '0;
  logic [DW-1:0]     dw [NREQ];
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]   ready;
  logic [DW-1:0]     port_o;
  logic              port_valid_o;
  logic [1:0]        port_src_o;
  logic              busy_o;

  assign data = {dw[2], dw[1], dw[0]};

  always #5 clk = ~clk;

  tdsp_port_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .IDLE_VAL(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .test_mode    (test_mode),
    .req          (req),
    .data         (data),
    .ready        (ready),
    .port_o       (port_o),
    .port_valid_o (port_valid_o),
    .port_src_o   (port_src_o),
    .busy_o       (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner (-1 = none), words sent, pointer, cool-down cycles
  int          m_owner, m_sent, m_ptr, m_cool, m_src;
  logic [15:0] m_port;
  bit          m_valid;

  function automatic void model_reset();
    m_owner = -1; m_sent = 0; m_ptr = 0; m_cool = 0; m_src = 0;
    m_port  = 16'h0000; m_valid = 1'b0;
  endfunction

  function automatic void model_edge();
    if (!reset) begin model_reset(); return; end
    m_port  = 16'h0000;
    m_valid = 1'b0;
    if (test_mode) begin
      m_owner = -1; m_cool = 0; m_sent = 0;
      return;
    end
    if (m_owner >= 0) begin
      if (req[m_owner]) begin
        m_port = dw[m_owner]; m_valid = 1'b1; m_src = m_owner; m_sent++;
      end
      if (!req[m_owner] || m_sent == MAX_BURST) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (req[c]) begin m_owner = c; m_sent = 0; break; end
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; test_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) dw[i] = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) dw[i] = '0;
    #2 reset = 1'b0;
    #1;
    n_tests++; if (port_o !== 16'h0000) begin n_fail++; $display("FAIL reset_port got %h exp 0000", port_o); end
    n_tests++; if (port_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", port_valid_o); end
    n_tests++; if (port_src_o !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d exp 0", port_src_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_tests++; if (ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b exp 000", ready); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [15:0] w [5];
    w[0] = 16'hA5A5; w[1] = 16'h5A5A; w[2] = 16'h1234; w[3] = 16'hBEEF; w[4] = 16'hCAFE;
    do_reset();
    req = 3'b010; dw[1] = w[0];
    tick();
    n_tests++; if (ready !== 3'b010) begin n_fail++; $display("FAIL single_ready got %b exp 010", ready); end
    for (int k = 0; k < 4; k++) begin
      dw[1] = w[k];
      tick();
      n_tests++;
      if (port_o !== w[k] || port_valid_o !== 1'b1 || port_src_o !== 2'd1) begin
        n_fail++; $display("FAIL single_word%0d got %h/%b/%0d exp %h/1/1", k, port_o, port_valid_o, port_src_o, w[k]);
      end
    end
    dw[1] = w[4];
    for (int g = 0; g < 2; g++) begin
      tick();
      n_tests++; if (port_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_gap%0d valid got %b exp 0", g, port_valid_o); end
    end
    tick();
    n_tests++;
    if (port_o !== 16'hCAFE || port_valid_o !== 1'b1 || port_src_o !== 2'd1) begin
      n_fail++; $display("FAIL single_fifth got %h/%b/%0d exp cafe/1/1", port_o, port_valid_o, port_src_o);
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_rotate();
    do_reset();
    req = 3'b111;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NREQ; i++) dw[i] = {4'(i), 12'(c)};
      tick();
      if (c >= 1) begin
        int seg, own;
        seg = (c - 1) % 6;
        own = ((c - 1) / 6) % 3;
        n_tests++;
        if (port_valid_o !== (seg < 4)) begin
          n_fail++; $display("FAIL rotate_valid c%0d got %b exp %b", c, port_valid_o, (seg < 4));
        end else if (seg < 4 && (port_src_o !== 2'(own) || port_o !== {4'(own), 12'(c)})) begin
          n_fail++; $display("FAIL rotate_word c%0d got %h/%0d exp %h/%0d", c, port_o, port_src_o, {4'(own), 12'(c)}, own);
        end
      end
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_drop();
    do_reset();
    req = 3'b011; dw[0] = 16'h0001; dw[1] = 16'h1111;
    tick();
    tick();
    n_tests++; if (port_o !== 16'h0001 || port_src_o !== 2'd0) begin n_fail++; $display("FAIL drop_w1 got %h/%0d exp 0001/0", port_o, port_src_o); end
    dw[0] = 16'h0002;
    tick();
    n_tests++; if (port_o !== 16'h0002 || port_valid_o !== 1'b1) begin n_fail++; $display("FAIL drop_w2 got %h/%b exp 0002/1", port_o, port_valid_o); end
    req = 3'b010;
    tick();
    n_tests++; if (port_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL drop_turn got v%b b%b exp v0 b1", port_valid_o, busy_o); end
    tick();
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL drop_idle busy got %b exp 0", busy_o); end
    tick();
    n_tests++; if (ready !== 3'b010) begin n_fail++; $display("FAIL drop_next_ready got %b exp 010", ready); end
    tick();
    n_tests++; if (port_o !== 16'h1111 || port_src_o !== 2'd1) begin n_fail++; $display("FAIL drop_next_word got %h/%0d exp 1111/1", port_o, port_src_o); end
    req = '0; tick(); tick();
  endtask

  task automatic test_test_mode();
    do_reset();
    req = 3'b010; dw[1] = 16'h0101;
    tick(); tick();
    req = 3'b000;
    tick(); tick();
    req = 3'b101; dw[0] = 16'h0F0F; dw[2] = 16'h2001;
    tick();
    n_tests++; if (ready !== 3'b100) begin n_fail++; $display("FAIL tm_first_ready got %b exp 100", ready); end
    tick();
    dw[2] = 16'h2002;
    tick();
    n_tests++; if (port_o !== 16'h2002 || port_src_o !== 2'd2) begin n_fail++; $display("FAIL tm_w2 got %h/%0d exp 2002/2", port_o, port_src_o); end
    test_mode = 1'b1;
    #1;
    n_tests++; if (ready !== 3'b000) begin n_fail++; $display("FAIL tm_ready got %b exp 000", ready); end
    tick();
    n_tests++; if (port_o !== 16'h0000 || port_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL tm_park got %h/%b/%b exp 0000/0/0", port_o, port_valid_o, busy_o);
    end
    tick();
    test_mode = 1'b0;
    tick();
    n_tests++; if (ready !== 3'b100) begin n_fail++; $display("FAIL tm_resume_ready got %b exp 100", ready); end
    dw[2] = 16'h2003;
    tick();
    n_tests++; if (port_o !== 16'h2003 || port_src_o !== 2'd2) begin n_fail++; $display("FAIL tm_resume_word got %h/%0d exp 2003/2", port_o, port_src_o); end
    req = '0; tick(); tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b001; dw[0] = 16'h0AAA; dw[1] = 16'h1BBB;
    tick(); tick();
    req = 3'b010;
    tick(); tick(); tick(); tick();
    n_tests++; if (port_valid_o !== 1'b1 || port_src_o !== 2'd1) begin n_fail++; $display("FAIL ar_pre got %b/%0d exp 1/1", port_valid_o, port_src_o); end
    #3 reset = 1'b0;
    #1;
    n_tests++; if (port_o !== 16'h0000 || port_valid_o !== 1'b0 || busy_o !== 1'b0 || ready !== 3'b000) begin
      n_fail++; $display("FAIL ar_immediate got %h/%b/%b/%b exp 0000/0/0/000", port_o, port_valid_o, busy_o, ready);
    end
    model_reset();
    #2 reset = 1'b1;
    req = 3'b011; dw[0] = 16'h0A0A;
    tick();
    n_tests++; if (ready !== 3'b001) begin n_fail++; $display("FAIL ar_restart_ready got %b exp 001", ready); end
    tick();
    n_tests++; if (port_o !== 16'h0A0A || port_src_o !== 2'd0) begin n_fail++; $display("FAIL ar_restart_word got %h/%0d exp 0a0a/0", port_o, port_src_o); end
    req = '0; tick(); tick();
  endtask

  task automatic test_nongranted();
    do_reset();
    req = 3'b001; dw[0] = 16'h7000;
    tick();
    for (int k = 0; k < 4; k++) begin
      dw[0] = 16'h7000 + 16'(k);
      dw[1] = 16'($urandom); dw[2] = 16'($urandom);
      req = {1'($urandom), 1'($urandom), 1'b1};
      #1;
      n_tests++; if (ready !== 3'b001) begin n_fail++; $display("FAIL ng_ready%0d got %b exp 001", k, ready); end
      tick();
      n_tests++; if (port_o !== 16'h7000 + 16'(k) || port_src_o !== 2'd0) begin
        n_fail++; $display("FAIL ng_word%0d got %h/%0d exp %h/0", k, port_o, port_src_o, 16'h7000 + 16'(k));
      end
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_ready;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        req[i] = ($urandom_range(0, 9) < 7);
        dw[i]  = 16'($urandom);
      end
      test_mode = ($urandom_range(0, 24) == 0);
      #1;
      exp_ready = (m_owner >= 0 && !test_mode) ? 3'(1 << m_owner) : 3'b000;
      n_tests++; if (ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready n%0d got %b exp %b", n, ready, exp_ready); end
      tick();
      n_tests++;
      if (port_o !== m_port || port_valid_o !== m_valid || port_src_o !== 2'(m_src) ||
          busy_o !== (m_owner >= 0 || m_cool > 0)) begin
        n_fail++;
        $display("FAIL rnd_out n%0d got %h/%b/%0d/%b exp %h/%b/%0d/%b", n, port_o, port_valid_o, port_src_o, busy_o,
                 m_port, m_valid, m_src, (m_owner >= 0 || m_cool > 0));
      end
    end
    test_mode = 1'b0; req = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotate();
    test_drop();
    test_test_mode();
    test_async_reset();
    test_nongranted();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdsp_port_arb.md
Name: tdsp_port_arb

Overview:
- Arbitrates and sequences the shared 16-bit tdsp_port_out pad bus between NREQ on-chip requesters: DSP core, tdigit formatter and SPI readback.
- Round-robin grant, bounded burst length, one-cycle turnaround gap between owners.
- Registered output feeds the output pad cells directly.
- test_mode parks the bus for scan.

Parameters:
NREQ, 3, number of requesters (2..4)
DW, 16, port data width
MAX_BURST, 4, maximum words per grant (1..15)
IDLE_VAL, 16'h0000, value driven on port_o when no transfer occurs

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
test_mode  input  1  scan/test override, synchronous effect
req  input  NREQ  per-requester request/valid
data  input  NREQ*DW  per-requester word; requester i occupies bits [i*DW +: DW]
ready  output  NREQ  per-requester accept, combinational from state
port_o  output  DW  registered word to output pads
port_valid_o  output  1  registered: port_o holds a transferred word this cycle
port_src_o  output  2  registered index of the requester that owns port_o
busy_o  output  1  state != IDLE

Behaviour:
- Interface: one clock clk. reset is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, burst_cnt=0, gnt_idx=0, port_o=IDLE_VAL, port_valid_o=0, port_src_o=0, ready=0.
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - If any req and !test_mode: select the first asserted req scanning from rr_ptr upward, wrapping modulo NREQ.
  - Load gnt_idx, clear burst_cnt, go to GRANT at the next edge.
  - This costs one arbitration cycle.
- GRANT:
  - ready[gnt_idx] = 1 when !test_mode; all other ready = 0.
  - Transfer = req[gnt_idx] && ready[gnt_idx].
  - On transfer: port_o <= data[gnt_idx], port_valid_o <= 1, port_src_o <= gnt_idx, burst_cnt++.
  - Latency: word accepted at edge N appears on port_o after edge N, i.e. one cycle.
- Leaving GRANT: go to TURN when either
  - a transfer occurs with burst_cnt == MAX_BURST-1, or
  - req[gnt_idx] is low (no transfer that cycle).
  - On leaving GRANT, set rr_ptr <= (gnt_idx+1) mod NREQ.
- TURN: exactly one cycle. port_o=IDLE_VAL, port_valid_o=0, ready=0. Then go to IDLE.
- Any cycle without a transfer: port_o <= IDLE_VAL, port_valid_o <= 0, port_src_o holds its last value.
- Minimum spacing between different owners is 2 idle bus cycles (TURN + IDLE). The same requester re-winning also pays both cycles.
- Simultaneous requests: round-robin only. A requester asserting req while another owns the bus waits. No preemption.
- Requests from non-granted requesters are ignored. Data must be held stable while req is high and ready is low.
- test_mode high:
  - ready=0 combinationally.
  - Next edge forces state=IDLE, port_o=IDLE_VAL, port_valid_o=0, burst_cnt=0.
  - rr_ptr is unchanged; an abandoned burst does not advance the pointer.
  - Arbitration resumes the cycle after test_mode falls.
- Reset asserted mid-burst: all registers return to reset values immediately. The partially sent burst is not resumed.
- burst_cnt is 4 bits and saturates at MAX_BURST-1; no wrap.
- port_src_o is 2 bits; NREQ > 4 is unsupported.

Decomposition:
- Package tdsp_port_pkg holds:
  - state enum {IDLE, GRANT, TURN}
  - requester index constants REQ_DSP=0, REQ_TDIG=1, REQ_SPI=2
  - IDLE_VAL default
  - DW default
- One sub-module, tdsp_rr_pick: combinational round-robin first-one finder.
  - Inputs: req, rr_ptr.
  - Outputs: gnt_idx, any.
  - Reusable by other pad-sharing arbiters.

Test Plan:
- Single requester: req[1]=1 with data 16'hA5A5, 16'h5A5A, 16'h1234, 16'hBEEF, 16'hCAFE → four words appear on port_o on consecutive cycles with port_src_o=1. Then 1 TURN cycle and 1 IDLE cycle with port_valid_o=0. Fifth word 16'hCAFE appears on the 3rd cycle after the fourth.
- All three request continuously from reset → grants rotate 0,1,2,0. Each owner sends 4 words; 2 invalid cycles separate owners.
- req[0] drops after 2 words 16'h0001, 16'h0002 → TURN next cycle. rr_ptr=1; req[1] pending is granted next.
- test_mode asserted mid-burst after word 2 of requester 2 → ready=0 that cycle; next edge port_o=16'h0000, port_valid_o=0, state IDLE. After release, requester 2 is granted again because rr_ptr is unchanged.
- Async reset pulse during GRANT, asserted between edges → port_o=0, port_valid_o=0, busy_o=0 immediately with no clock edge needed. After release, arbitration starts from requester 0.
- Non-granted requester toggles req and data during another's burst → no effect on port_o or ready.
